psx_poll_sequencer: RTL and testbench

- Self-contained master for the DualShock/PSX joystick port (psx_clk/psx_sel/psx_cmd/psx_dat).
- Polls the pad at a fixed frame rate, shifts a 5-byte read-buttons transaction, validates the reply, and publishes a debounced-by-frame button word plus status to the core.
- Replaces the external 250 kHz clock generator: all timing is derived from the single system clock through clock-enable ticks.

---
 rtl/psx_poll_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_psx_poll_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/psx_poll_sequencer.sv
// PSX/DualShock pad poller: frame-rate polling, 5-byte read-buttons exchange,
// reply validation and a per-frame button/status publish. Timing from clk enables only.
module psx_poll_sequencer #(
    parameter int CLK_HZ  = 25_200_000,
    parameter int SCLK_HZ = 250_000,
    parameter int POLL_HZ = 60,
    parameter int GAP_HP  = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    output logic        psx_clk,
    output logic        psx_sel,
    output logic        psx_cmd,
    input  logic        psx_dat,
    output logic [15:0] btn,
    output logic [7:0]  pad_id,
    output logic        valid,
    output logic        err,
    output logic        done
);
    localparam int HALF     = CLK_HZ / (2 * SCLK_HZ);
    localparam int POLL_DIV = CLK_HZ / POLL_HZ;
    localparam int TXN_HP   = 2 + 5 * 16 + 5 * GAP_HP + 2;
    localparam int PW       = $clog2(POLL_DIV);
    localparam int HW       = $clog2(HALF);
    localparam int HPW      = $clog2(GAP_HP) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_TAIL  = 3'd4;

    localparam logic [4:0][7:0] CMD = {8'h00, 8'h00, 8'h00, 8'h42, 8'h01};

    if (HALF < 4) begin : g_chk_half
        $error("psx_poll_sequencer: HALF must be >= 4");
    end
    if (TXN_HP * HALF >= POLL_DIV) begin : g_chk_len
        $error("psx_poll_sequencer: transaction longer than poll period");
    end

    logic [2:0]      state_q, state_d;
    logic [PW-1:0]   poll_q, poll_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [HPW-1:0]  hpn_q, hpn_d;
    logic [2:0]      byte_q, byte_d, bit_q, bit_d;
    logic            ph_q, ph_d;
    logic            clk_q, clk_d, sel_q, sel_d, cmd_q, cmd_d;
    logic [4:0][7:0] rx_q, rx_d;
    logic [15:0]     btn_q, btn_d;
    logic [7:0]      id_q, id_d;
    logic            valid_q, valid_d, err_q, err_d, done_q, done_d;
    logic            dat_s1_q, dat_s2_q;
    logic            start, tick, pass;
    logic [2:0]      byte_n, bit_n;

    assign start  = (poll_q == PW'(POLL_DIV - 1));
    assign tick   = (hcnt_q == HW'(HALF - 1));
    assign byte_n = byte_q + 3'd1;
    assign bit_n  = bit_q + 3'd1;
    assign pass   = ((rx_q[1] == 8'h41) || (rx_q[1] == 8'h73)) && (rx_q[2] == 8'h5A);

    always_comb begin
        state_d = state_q;
        poll_d  = start ? '0 : poll_q + 1'b1;
        hcnt_d  = (tick || state_q == S_IDLE) ? '0 : hcnt_q + 1'b1;
        hpn_d   = hpn_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        ph_d    = ph_q;
        clk_d   = clk_q;
        sel_d   = sel_q;
        cmd_d   = cmd_q;
        rx_d    = rx_q;
        btn_d   = btn_q;
        id_d    = id_q;
        valid_d = valid_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: if (start && enable) begin
                state_d = S_SETUP;
                sel_d   = 1'b0;
                hpn_d   = '0;
            end
            S_SETUP: if (tick) begin
                if (hpn_q == HPW'(1)) begin
                    state_d = S_SHIFT;
                    hpn_d   = '0;
                    byte_d  = 3'd0;
                    bit_d   = 3'd0;
                    ph_d    = 1'b0;
                    clk_d   = 1'b0;
                    cmd_d   = CMD[0][0];
                end else begin
                    hpn_d = hpn_q + 1'b1;
                end
            end
            S_SHIFT: if (tick) begin
                // ph=0: low half ending, sample on the rising edge we are about to drive
                if (!ph_q) begin
                    clk_d                = 1'b1;
                    ph_d                 = 1'b1;
                    rx_d[byte_q][bit_q]  = dat_s2_q;
                end else if (bit_q == 3'd7) begin
                    state_d = S_GAP;
                    cmd_d   = 1'b1;
                    hpn_d   = '0;
                end else begin
                    bit_d = bit_n;
                    ph_d  = 1'b0;
                    clk_d = 1'b0;
                    cmd_d = CMD[byte_q][bit_n];
                end
            end
            S_GAP: if (tick) begin
                if (hpn_q == HPW'(GAP_HP - 1)) begin
                    hpn_d = '0;
                    if (byte_q < 3'd4) begin
                        state_d = S_SHIFT;
                        byte_d  = byte_n;
                        bit_d   = 3'd0;
                        ph_d    = 1'b0;
                        clk_d   = 1'b0;
                        cmd_d   = CMD[byte_n][0];
                    end else begin
                        state_d = S_TAIL;
                    end
                end else begin
                    hpn_d = hpn_q + 1'b1;
                end
            end
            S_TAIL: if (tick) begin
                if (hpn_q == HPW'(1)) begin
                    state_d = S_IDLE;
                    sel_d   = 1'b1;
                    done_d  = 1'b1;
                    valid_d = pass;
                    err_d   = !pass;
                    btn_d   = pass ? ~{rx_q[4], rx_q[3]} : 16'h0000;
                    if (pass) id_d = rx_q[1];
                end else begin
                    hpn_d = hpn_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            poll_q   <= '0;
            hcnt_q   <= '0;
            hpn_q    <= '0;
            byte_q   <= '0;
            bit_q    <= '0;
            ph_q     <= 1'b0;
            clk_q    <= 1'b1;
            sel_q    <= 1'b1;
            cmd_q    <= 1'b1;
            rx_q     <= '0;
            btn_q    <= '0;
            id_q     <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            poll_q   <= poll_d;
            hcnt_q   <= hcnt_d;
            hpn_q    <= hpn_d;
            byte_q   <= byte_d;
            bit_q    <= bit_d;
            ph_q     <= ph_d;
            clk_q    <= clk_d;
            sel_q    <= sel_d;
            cmd_q    <= cmd_d;
            rx_q     <= rx_d;
            btn_q    <= btn_d;
            id_q     <= id_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            done_q   <= done_d;
            dat_s1_q <= psx_dat;
            dat_s2_q <= dat_s1_q;
        end
    end

    assign psx_clk = clk_q;
    assign psx_sel = sel_q;
    assign psx_cmd = cmd_q;
    assign btn     = btn_q;
    assign pad_id  = id_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign done    = done_q;
endmodule

// File: tb/tb_psx_poll_sequencer.sv
// Directed bench for psx_poll_sequencer with a shift-register pad model.
module tb_psx_poll_sequencer;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b1;
    logic        psx_clk, psx_sel, psx_cmd, psx_dat;
    logic [15:0] btn;
    logic [7:0]  pad_id;
    logic        valid, err, done;

    localparam logic [39:0] DIG = 40'hFF_FE_5A_41_FF;
    localparam logic [39:0] ANA = 40'hBF_EF_5A_73_FF;

    int nvec = 0, nerr = 0;
    int sel_falls = 0, dones = 0, lo_run = 0, lo_min = 99, lo_max = 0;
    int d0, f0;
    logic [39:0] reply = DIG;
    logic [39:0] pad_sh = '1;
    logic [39:0] cmd_sh = '0;
    logic        nopad = 1'b0;
    logic        prev_sel = 1'b1, prev_clk = 1'b1;

    psx_poll_sequencer #(.CLK_HZ(1000), .SCLK_HZ(100), .POLL_HZ(1), .GAP_HP(4)) dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .psx_clk(psx_clk), .psx_sel(psx_sel), .psx_cmd(psx_cmd), .psx_dat(psx_dat),
        .btn(btn), .pad_id(pad_id), .valid(valid), .err(err), .done(done)
    );

    always #5 clk = ~clk;

    assign psx_dat = nopad ? 1'b1 : pad_sh[0];

    // Pad model and monitors: pad loads on select, advances after each psx_clk rise.
    always @(negedge clk) begin
        if (prev_sel && !psx_sel) begin
            pad_sh = reply;
            cmd_sh = '0;
            sel_falls++;
            lo_min = 99;
            lo_max = 0;
        end
        if (!prev_clk && psx_clk && !psx_sel) begin
            cmd_sh = {psx_cmd, cmd_sh[39:1]};
            pad_sh = {1'b1, pad_sh[39:1]};
        end
        if (!psx_clk) lo_run++;
        else if (lo_run != 0) begin
            if (lo_run < lo_min) lo_min = lo_run;
            if (lo_run > lo_max) lo_max = lo_run;
            lo_run = 0;
        end
        if (done) dones++;
        prev_sel = psx_sel;
        prev_clk = psx_clk;
    end

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int maxc, input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check({tag, " done"}, 40'(seen), 40'd1);
    endtask

    task automatic wait_sel_fall(input int maxc, input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(posedge clk); #1;
            if (!psx_sel) seen = 1'b1;
        end
        check({tag, " sel fall"}, 40'(seen), 40'd1);
    endtask

    task automatic start_at_1000(input string tag);
        repeat (999) @(posedge clk);
        #1 check({tag, " sel high at 999"}, 40'(psx_sel), 40'd1);
        @(posedge clk);
        #1 check({tag, " sel low at 1000"}, 40'(psx_sel), 40'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst sel", 40'(psx_sel), 40'd1);
        check("rst clk", 40'(psx_clk), 40'd1);
        check("rst cmd", 40'(psx_cmd), 40'd1);
        check("rst btn", 40'(btn), 40'h0);
        check("rst pad_id", 40'(pad_id), 40'h0);
        check("rst valid", 40'(valid), 40'd0);
        check("rst err", 40'(err), 40'd0);
        check("rst done", 40'(done), 40'd0);

        @(negedge clk) resetn = 1'b1;
        start_at_1000("first");
        d0 = dones;
        wait_done(700, "digital");
        check("dig btn", 40'(btn), 40'h0001);
        check("dig pad_id", 40'(pad_id), 40'h41);
        check("dig valid", 40'(valid), 40'd1);
        check("dig err", 40'(err), 40'd0);
        check("dig cmd bytes", cmd_sh, 40'h00_00_00_42_01);
        check("dig low min", 40'(lo_min), 40'd5);
        check("dig low max", 40'(lo_max), 40'd5);
        repeat (5) @(posedge clk);
        #1 check("dig done count", 40'(dones - d0), 40'd1);

        nopad = 1'b1;
        wait_done(1200, "nopad");
        check("nopad err", 40'(err), 40'd1);
        check("nopad valid", 40'(valid), 40'd0);
        check("nopad btn", 40'(btn), 40'h0);
        check("nopad pad_id", 40'(pad_id), 40'h41);

        nopad = 1'b0;
        reply = ANA;
        wait_done(1200, "analog");
        check("ana btn", 40'(btn), 40'h4010);
        check("ana pad_id", 40'(pad_id), 40'h73);
        check("ana valid", 40'(valid), 40'd1);
        check("ana err", 40'(err), 40'd0);

        enable = 1'b0;
        f0 = sel_falls;
        repeat (3000) @(posedge clk);
        #1 check("disabled no sel", 40'(sel_falls - f0), 40'd0);
        check("disabled sel high", 40'(psx_sel), 40'd1);

        enable = 1'b1;
        wait_sel_fall(1200, "en-drop");
        repeat (250) @(posedge clk);
        #1 enable = 1'b0;
        d0 = dones;
        wait_done(400, "en-drop");
        f0 = sel_falls;
        repeat (1000) @(posedge clk);
        #1 check("en-drop done count", 40'(dones - d0), 40'd1);
        check("en-drop no next sel", 40'(sel_falls - f0), 40'd0);

        enable = 1'b1;
        wait_sel_fall(1200, "rst-mid");
        repeat (380) @(posedge clk);
        #1 d0 = dones;
        resetn = 1'b0;
        #1;
        check("rst-mid sel", 40'(psx_sel), 40'd1);
        check("rst-mid clk", 40'(psx_clk), 40'd1);
        check("rst-mid btn", 40'(btn), 40'h0);
        repeat (20) @(posedge clk);
        #1 check("rst-mid no done", 40'(dones - d0), 40'd0);
        @(negedge clk) resetn = 1'b1;
        start_at_1000("post-rst");
        wait_done(700, "post-rst");
        check("post-rst btn", 40'(btn), 40'h4010);
        check("post-rst pad_id", 40'(pad_id), 40'h73);
        check("post-rst valid", 40'(valid), 40'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
